// File: rtl/hyst_ctrl.sv
// Frame sequencer for the hysteresis threshold stage.
// Feeds per-pixel (angle, magnitude window) beats through the external
// combinational hyst datapath. It registers the 0/255 result together with
// its row/col on a 1-deep valid/ready output stage. It zeroes border pixels
// when asked to, and pulses frame_done once the last pixel of the frame has
// been taken downstream.
module hyst_ctrl #(
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 240,
  parameter int BORDER_ZERO = 1,
  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_angle,
  input  logic [4:0][7:0] in_mag,
  output logic [1:0]      hyst_angle,
  output logic [4:0][7:0] hyst_mag,
  input  logic [7:0]      hyst_pixel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_pixel,
  output logic [CW-1:0]   out_col,
  output logic [RW-1:0]   out_row,
  output logic            busy,
  output logic            frame_done
);

  localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic            r_out_valid;
  logic [7:0]      r_out_pixel;
  logic [CW-1:0]   r_out_col;
  logic [RW-1:0]   r_out_row;

  logic            w_in_ready;
  logic            w_accept;
  logic            w_take;
  logic            w_start_go;
  logic            w_last_col;
  logic            w_last_row;
  logic            w_border;
  logic            w_busy;
  logic            w_frame_done;

  // The datapath is pure combinational, so its result is consumed this cycle.
  assign hyst_angle = in_angle;
  assign hyst_mag   = in_mag;

  assign w_accept   = in_valid && w_in_ready;
  assign w_take     = r_out_valid && out_ready;
  assign w_start_go = (r_state == S_IDLE) && start;
  assign w_last_col = (r_col == COL_MAX);
  assign w_last_row = (r_row == ROW_MAX);
  assign w_border   = (BORDER_ZERO != 0) &&
                      ((r_col == '0) || w_last_col || (r_row == '0) || w_last_row);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, input handshake and status outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_in_ready   = 1'b0;
    w_busy       = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_busy     = 1'b1;
        // Accept whenever the output slot is empty or being emptied now.
        w_in_ready = !r_out_valid || out_ready;
        if (w_in_ready && in_valid && w_last_col && w_last_row)
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (w_take) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_frame_done = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Raster position of the next accepted beat; wraps to 0,0 after the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_start_go) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Output stage: a new accept reloads even while the old beat is being taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_pixel <= '0;
      r_out_col   <= '0;
      r_out_row   <= '0;
    end else if (w_start_go) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_pixel <= w_border ? 8'd0 : hyst_pixel;
      r_out_col   <= r_col;
      r_out_row   <= r_row;
    end else if (w_take) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_pixel  = r_out_pixel;
  assign out_col    = r_out_col;
  assign out_row    = r_out_row;
  assign busy       = w_busy;
  assign frame_done = w_frame_done;

endmodule

// File: tb/tb_hyst_ctrl.sv
// Bench for hyst_ctrl: two 4x3 instances (a: no border zeroing, b: border
// zeroing). A small hysteresis model stands in for the datapath. Drivers push
// the expected pixel/row/col on every accept; a monitor pops and compares on
// every output take, and checks frame_done against the last take.
module tb_hyst_ctrl;
  localparam int W = 4;
  localparam int H = 3;
  localparam int TMO = 200;
  localparam int NRND = 15;
  localparam logic [7:0] HI = 8'd140;
  localparam logic [7:0] LO = 8'd70;

  typedef struct packed {
    logic [7:0] pix;
    logic [1:0] row;
    logic [1:0] col;
    logic       last;
  } exp_t;

  logic clk;
  logic rst [2];
  logic start [2];
  logic in_valid [2];
  logic in_ready [2];
  logic out_valid [2];
  logic out_ready [2];
  logic busy [2];
  logic frame_done [2];
  logic [1:0] in_angle [2];
  logic [1:0] hyst_angle [2];
  logic [4:0][7:0] in_mag [2];
  logic [4:0][7:0] hyst_mag [2];
  logic [7:0] hyst_pixel [2];
  logic [7:0] out_pixel [2];
  logic [1:0] out_col [2];
  logic [1:0] out_row [2];

  int n_chk = 0;
  int n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];
  int brow [2];
  int bcol [2];
  int fd_cnt [2];
  int exp_fd [2];
  int rdy_mode [2];
  logic prev_last [2];

  function automatic logic [7:0] hyst_ref(input logic [1:0] a, input logic [4:0][7:0] m);
    if (m[4] >= HI) return 8'd255;
    if (m[4] >= LO && m[a] >= HI) return 8'd255;
    return 8'd0;
  endfunction

  function automatic logic [4:0][7:0] mk(input logic [7:0] c, input logic [7:0] n3,
                                         input logic [7:0] n2, input logic [7:0] n1,
                                         input logic [7:0] n0);
    return {c, n3, n2, n1, n0};
  endfunction

  function automatic logic [4:0][7:0] ctr(input logic [7:0] c);
    return {c, 8'd0, 8'd0, 8'd0, 8'd0};
  endfunction

  assign hyst_pixel[0] = hyst_ref(hyst_angle[0], hyst_mag[0]);
  assign hyst_pixel[1] = hyst_ref(hyst_angle[1], hyst_mag[1]);

  hyst_ctrl #(.WIDTH(W), .HEIGHT(H), .BORDER_ZERO(0)) u_dut_a (
    .clk(clk), .rst(rst[0]), .start(start[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_angle(in_angle[0]), .in_mag(in_mag[0]), .hyst_angle(hyst_angle[0]), .hyst_mag(hyst_mag[0]),
    .hyst_pixel(hyst_pixel[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_pixel(out_pixel[0]), .out_col(out_col[0]), .out_row(out_row[0]),
    .busy(busy[0]), .frame_done(frame_done[0]));

  hyst_ctrl #(.WIDTH(W), .HEIGHT(H), .BORDER_ZERO(1)) u_dut_b (
    .clk(clk), .rst(rst[1]), .start(start[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_angle(in_angle[1]), .in_mag(in_mag[1]), .hyst_angle(hyst_angle[1]), .hyst_mag(hyst_mag[1]),
    .hyst_pixel(hyst_pixel[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_pixel(out_pixel[1]), .out_col(out_col[1]), .out_row(out_row[1]),
    .busy(busy[1]), .frame_done(frame_done[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Record the expected output for the beat just accepted and advance the raster model.
  task automatic push(input int k, input logic [7:0] pix);
    exp_t e;
    e.pix  = pix;
    e.row  = 2'(brow[k]);
    e.col  = 2'(bcol[k]);
    e.last = (brow[k] == H-1) && (bcol[k] == W-1);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
    if (bcol[k] == W-1) begin
      bcol[k] = 0;
      brow[k] = (brow[k] == H-1) ? 0 : brow[k] + 1;
    end else begin
      bcol[k] = bcol[k] + 1;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic beat(input int k, input logic [1:0] ang, input logic [4:0][7:0] mag,
                      input logic [7:0] pix);
    int n;
    n = 0;
    in_valid[k] = 1'b1;
    in_angle[k] = ang;
    in_mag[k]   = mag;
    forever begin
      @(negedge clk);
      if (in_ready[k]) begin
        push(k, pix);
        break;
      end
      n++;
      if (n >= TMO) begin
        n_chk++;
        n_fail++;
        $display("FAIL accept_timeout dut%0d: in_ready stayed 0, expected 1", k);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
  endtask

  task automatic do_start(input int k);
    brow[k] = 0;
    bcol[k] = 0;
    start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy[k] && !frame_done[k] && (((k == 0) ? q0.size() : q1.size()) == 0)) break;
      n++;
      if (n >= TMO) begin
        n_chk++;
        n_fail++;
        $display("FAIL drain_timeout dut%0d: busy=%0d pending=%0d, expected idle and 0",
                 k, busy[k], (k == 0) ? q0.size() : q1.size());
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input int k);
    chk($sformatf("rst_out_valid dut%0d", k), 32'(out_valid[k]), 32'd0);
    chk($sformatf("rst_out_pixel dut%0d", k), 32'(out_pixel[k]), 32'd0);
    chk($sformatf("rst_out_col dut%0d", k), 32'(out_col[k]), 32'd0);
    chk($sformatf("rst_out_row dut%0d", k), 32'(out_row[k]), 32'd0);
    chk($sformatf("rst_busy dut%0d", k), 32'(busy[k]), 32'd0);
    chk($sformatf("rst_frame_done dut%0d", k), 32'(frame_done[k]), 32'd0);
    chk($sformatf("rst_in_ready dut%0d", k), 32'(in_ready[k]), 32'd0);
  endtask

  // Downstream ready: 0 = always ready, 1 = random 50%, 2 = stalled.
  initial begin
    out_ready[0] = 1'b0;
    out_ready[1] = 1'b0;
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        case (rdy_mode[k])
          0:       out_ready[k] = 1'b1;
          1:       out_ready[k] = 1'($urandom_range(0, 1));
          default: out_ready[k] = 1'b0;
        endcase
      end
    end
  end

  // Monitor: compare every taken output against the scoreboard and check frame_done timing.
  initial begin
    prev_last[0] = 1'b0;
    prev_last[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst[k]) begin
          prev_last[k] = 1'b0;
        end else begin
          exp_t e;
          int sz;
          chk($sformatf("frame_done dut%0d", k), 32'(frame_done[k]), 32'(prev_last[k]));
          if (frame_done[k]) fd_cnt[k]++;
          prev_last[k] = 1'b0;
          if (out_valid[k] && out_ready[k]) begin
            sz = (k == 0) ? q0.size() : q1.size();
            if (sz == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL unexpected_output dut%0d: got row %0d col %0d, expected no output",
                       k, out_row[k], out_col[k]);
            end else begin
              if (k == 0) e = q0.pop_front();
              else        e = q1.pop_front();
              chk($sformatf("pixel dut%0d r%0d c%0d", k, e.row, e.col), 32'(out_pixel[k]), 32'(e.pix));
              chk($sformatf("row dut%0d", k), 32'(out_row[k]), 32'(e.row));
              chk($sformatf("col dut%0d", k), 32'(out_col[k]), 32'(e.col));
              prev_last[k] = e.last;
            end
          end
        end
      end
    end
  end

  initial begin
    logic [4:0][7:0] m;
    logic [1:0] a;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; start[k] = 1'b0; in_valid[k] = 1'b0;
      in_angle[k] = '0; in_mag[k] = '0; rdy_mode[k] = 0;
      fd_cnt[k] = 0; exp_fd[k] = 0; brow[k] = 0; bcol[k] = 0;
    end
    repeat (2) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(posedge clk); #1;

    // Plain frame, every pixel strong.
    do_start(0);
    for (int i = 0; i < W*H; i++) beat(0, 2'd0, ctr(8'd150), 8'd255);
    wait_idle(0);
    exp_fd[0]++;
    chk("frames_after_first dut0", 32'(fd_cnt[0]), 32'd1);

    // Border zeroing: only the two interior pixels survive.
    do_start(1);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        beat(1, 2'd0, {5{8'd200}}, (r == 1 && (c == 1 || c == 2)) ? 8'd255 : 8'd0);
    wait_idle(1);
    exp_fd[1]++;

    // Weak/strong threshold vectors and angle selection.
    do_start(0);
    for (int i = 0; i < W*H; i++) begin
      case (i)
        4:       beat(0, 2'd2, mk(8'd80, 8'd0, 8'd150, 8'd0, 8'd0), 8'd255);
        5:       beat(0, 2'd2, mk(8'd60, 8'd0, 8'd200, 8'd0, 8'd0), 8'd0);
        6:       beat(0, 2'd0, ctr(8'd139), 8'd0);
        7:       beat(0, 2'd1, mk(8'd100, 8'd0, 8'd0, 8'd140, 8'd0), 8'd255);
        8:       beat(0, 2'd3, mk(8'd70, 8'd139, 8'd0, 8'd0, 8'd0), 8'd0);
        9:       beat(0, 2'd3, mk(8'd70, 8'd140, 8'd0, 8'd0, 8'd0), 8'd255);
        10:      beat(0, 2'd0, mk(8'd120, 8'd200, 8'd200, 8'd200, 8'd0), 8'd0);
        default: beat(0, 2'd0, ctr(8'd150), 8'd255);
      endcase
    end
    wait_idle(0);
    exp_fd[0]++;

    // Downstream stall mid-frame.
    do_start(0);
    for (int i = 0; i < 5; i++) beat(0, 2'd0, ctr(8'd150), 8'd255);
    repeat (3) begin @(posedge clk); #1; end
    rdy_mode[0] = 2;
    repeat (2) begin @(posedge clk); #1; end
    beat(0, 2'd0, ctr(8'd150), 8'd255);
    fork
      beat(0, 2'd0, ctr(8'd150), 8'd255);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready[0]), 32'd0);
          chk("stall_out_valid", 32'(out_valid[0]), 32'd1);
          chk("stall_out_row", 32'(out_row[0]), 32'd1);
          chk("stall_out_col", 32'(out_col[0]), 32'd1);
          chk("stall_out_pixel", 32'(out_pixel[0]), 32'd255);
        end
        rdy_mode[0] = 0;
      end
    join
    for (int i = 7; i < W*H; i++) beat(0, 2'd0, ctr(8'd150), 8'd255);
    wait_idle(0);
    exp_fd[0]++;

    // in_valid in IDLE is ignored.
    in_valid[0] = 1'b1;
    in_mag[0] = ctr(8'd150);
    repeat (3) begin
      @(negedge clk);
      chk("idle_in_ready", 32'(in_ready[0]), 32'd0);
      chk("idle_out_valid", 32'(out_valid[0]), 32'd0);
      chk("idle_busy", 32'(busy[0]), 32'd0);
    end
    @(posedge clk); #1;
    in_valid[0] = 1'b0;

    // start during RUN is ignored; reset after the 6th beat aborts the frame.
    do_start(0);
    for (int i = 0; i < 6; i++) begin
      beat(0, 2'd0, ctr(8'd150), 8'd255);
      if (i == 2) begin
        start[0] = 1'b1;
        @(negedge clk);
        chk("run_busy", 32'(busy[0]), 32'd1);
        @(posedge clk); #1;
        start[0] = 1'b0;
      end
    end
    rst[0] = 1'b1;
    q0.delete();
    @(negedge clk);
    chk_reset(0);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    @(posedge clk); #1;

    // Fresh frame after abort must restart at (0,0).
    do_start(0);
    for (int i = 0; i < W*H; i++) begin
      a = 2'($urandom_range(0, 3));
      m = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      beat(0, a, m, hyst_ref(a, m));
    end
    wait_idle(0);
    exp_fd[0]++;

    // Random valid/ready at 50% on both instances.
    rdy_mode[0] = 1;
    rdy_mode[1] = 1;
    for (int k = 0; k < 2; k++) begin
      for (int f = 0; f < NRND; f++) begin
        do_start(k);
        for (int r = 0; r < H; r++) begin
          for (int c = 0; c < W; c++) begin
            while ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
            a = 2'($urandom_range(0, 3));
            m = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
            if (k == 1 && (r == 0 || r == H-1 || c == 0 || c == W-1))
              beat(k, a, m, 8'd0);
            else
              beat(k, a, m, hyst_ref(a, m));
          end
        end
        wait_idle(k);
        exp_fd[k]++;
      end
    end

    chk("frame_count dut0", 32'(fd_cnt[0]), 32'(exp_fd[0]));
    chk("frame_count dut1", 32'(fd_cnt[1]), 32'(exp_fd[1]));
    chk("pending dut0", 32'(q0.size()), 32'd0);
    chk("pending dut1", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
